// File: rtl/writeback_ctrl_pkg.sv
// writeback_ctrl_pkg
// Shared definitions for the register-file write-back sequencer:
//   - estado_t : 2-bit FSM state encoding (IDLE, EXEC, MEM_WAIT, WRITE)
//   - TIPO_*   : encodings of the write-back source carried on `tipo`
//   - selecoes_de() : maps a write-back type onto the {selecao2, selecao1}
//                     mux select pair (one-hot or zero, never both high)
package writeback_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_WRITE    = 2'd3
    } estado_t;

    localparam logic [1:0] TIPO_ULA    = 2'b00;
    localparam logic [1:0] TIPO_MEM    = 2'b01;
    localparam logic [1:0] TIPO_PC     = 2'b10;
    localparam logic [1:0] TIPO_NENHUM = 2'b11;

    localparam int unsigned WATCHDOG_WIDTH = 8;

    // Returns {selecao2, selecao1}; ALU and no-write keep the mux on its default input.
    function automatic logic [1:0] selecoes_de(input logic [1:0] tipo);
        logic [1:0] sel;
        case (tipo)
            TIPO_MEM: sel = 2'b01;
            TIPO_PC:  sel = 2'b10;
            default:  sel = 2'b00;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/writeback_ctrl_watchdog.sv
// writeback_watchdog
// 8-bit cycle counter that bounds the time spent waiting for data memory.
// Ports:
//   clock_i    : clock, rising edge
//   reset_n_i  : asynchronous active-low reset
//   limpa_i    : synchronous clear (held while not waiting on memory)
//   habilita_i : count enable (one increment per waiting cycle)
//   expirou_o  : high during the waiting cycle in which the count reaches LIMITE
module writeback_watchdog
    import writeback_ctrl_pkg::*;
#(
    parameter int unsigned LIMITE = 16
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic limpa_i,
    input  logic habilita_i,
    output logic expirou_o
);

    // The count during the k-th waiting cycle is k-1, so the limit is hit one below LIMITE.
    localparam logic [WATCHDOG_WIDTH-1:0] ULTIMO = WATCHDOG_WIDTH'(LIMITE - 1);

    logic [WATCHDOG_WIDTH-1:0] conta_q;

    // Wait-cycle counter: clear outside the wait, increment while waiting.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            conta_q <= {WATCHDOG_WIDTH{1'b0}};
        end else if (limpa_i) begin
            conta_q <= {WATCHDOG_WIDTH{1'b0}};
        end else if (habilita_i) begin
            conta_q <= conta_q + {{(WATCHDOG_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            conta_q <= conta_q;
        end
    end

    assign expirou_o = habilita_i && (conta_q == ULTIMO);

endmodule

// File: rtl/writeback_ctrl.sv
// writeback_ctrl
// Multicycle sequencer for the register-file write-back path. One instruction
// at a time is stepped through EXEC, an optional MEM_WAIT and a WRITE cycle.
// Every output is a register; nothing passes combinationally from input to output.
// Optional feature: define WRITEBACK_CTRL_TIMEOUT_EN to abort a MEM_WAIT
// that lasts TIMEOUT_CICLOS cycles (pulses `erro`); otherwise the wait is
// unbounded and `erro` is constant 0.
// Ports:
//   clock, reset_n         : clock (rising edge), asynchronous active-low reset
//   inicio, tipo, rd_entrada : start request, write-back source, destination
//   mem_pronto             : data-memory read data valid
//   mem_req                : memory request, high throughout MEM_WAIT
//   selecao1, selecao2     : write-back mux selects (memory / PC)
//   escreve_reg, rd_saida  : register-file write enable and address
//   ocupado, concluido, erro : busy, retire pulse, timeout pulse
module writeback_ctrl
    import writeback_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned TIMEOUT_CICLOS = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      inicio,
    input  logic [1:0]                tipo,
    input  logic [REG_ADDR_WIDTH-1:0] rd_entrada,
    input  logic                      mem_pronto,
    output logic                      mem_req,
    output logic                      selecao1,
    output logic                      selecao2,
    output logic                      escreve_reg,
    output logic [REG_ADDR_WIDTH-1:0] rd_saida,
    output logic                      ocupado,
    output logic                      concluido,
    output logic                      erro
);

    estado_t                   estado_q;
    logic [1:0]                tipo_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      mem_req_q;
    logic                      sel1_q;
    logic                      sel2_q;
    logic                      escreve_q;
    logic                      ocupado_q;
    logic                      concluido_q;
    logic                      erro_q;
    logic                      timeout_s;

`ifdef WRITEBACK_CTRL_TIMEOUT_EN
    writeback_watchdog #(
        .LIMITE     (TIMEOUT_CICLOS)
    ) u_watchdog (
        .clock_i    (clock),
        .reset_n_i  (reset_n),
        .limpa_i    (estado_q != ST_MEM_WAIT),
        .habilita_i (estado_q == ST_MEM_WAIT),
        .expirou_o  (timeout_s)
    );
`else
    localparam logic [7:0] TIMEOUT_LIMITE = 8'(TIMEOUT_CICLOS);
    logic unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT_LIMITE;
    assign timeout_s        = 1'b0;
`endif

    // Sequencer FSM; every output is registered together with the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q    <= ST_IDLE;
            tipo_q      <= TIPO_ULA;
            rd_q        <= {REG_ADDR_WIDTH{1'b0}};
            mem_req_q   <= 1'b0;
            sel1_q      <= 1'b0;
            sel2_q      <= 1'b0;
            escreve_q   <= 1'b0;
            ocupado_q   <= 1'b0;
            concluido_q <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            // Pulse outputs default low; only the transitions below raise them.
            escreve_q   <= 1'b0;
            concluido_q <= 1'b0;
            erro_q      <= 1'b0;
            case (estado_q)
                ST_IDLE: begin
                    if (inicio) begin
                        estado_q  <= ST_EXEC;
                        tipo_q    <= tipo;
                        rd_q      <= rd_entrada;
                        {sel2_q, sel1_q} <= selecoes_de(tipo);
                        ocupado_q <= 1'b1;
                    end else begin
                        estado_q  <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    case (tipo_q)
                        TIPO_MEM: begin
                            estado_q  <= ST_MEM_WAIT;
                            mem_req_q <= 1'b1;
                        end
                        TIPO_ULA, TIPO_PC: begin
                            estado_q    <= ST_WRITE;
                            escreve_q   <= 1'b1;
                            concluido_q <= 1'b1;
                        end
                        default: begin
                            // No-write retires straight from EXEC.
                            estado_q    <= ST_IDLE;
                            concluido_q <= 1'b1;
                            ocupado_q   <= 1'b0;
                            sel1_q      <= 1'b0;
                            sel2_q      <= 1'b0;
                        end
                    endcase
                end
                ST_MEM_WAIT: begin
                    // Data arriving on the limit cycle still wins over the timeout.
                    if (mem_pronto) begin
                        estado_q    <= ST_WRITE;
                        mem_req_q   <= 1'b0;
                        escreve_q   <= 1'b1;
                        concluido_q <= 1'b1;
                    end else if (timeout_s) begin
                        estado_q    <= ST_IDLE;
                        mem_req_q   <= 1'b0;
                        erro_q      <= 1'b1;
                        ocupado_q   <= 1'b0;
                        sel1_q      <= 1'b0;
                        sel2_q      <= 1'b0;
                    end else begin
                        estado_q    <= ST_MEM_WAIT;
                    end
                end
                ST_WRITE: begin
                    estado_q  <= ST_IDLE;
                    ocupado_q <= 1'b0;
                    sel1_q    <= 1'b0;
                    sel2_q    <= 1'b0;
                end
                default: begin
                    estado_q  <= ST_IDLE;
                    mem_req_q <= 1'b0;
                    ocupado_q <= 1'b0;
                    sel1_q    <= 1'b0;
                    sel2_q    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign selecao1    = sel1_q;
    assign selecao2    = sel2_q;
    assign escreve_reg = escreve_q;
    assign rd_saida    = rd_q;
    assign ocupado     = ocupado_q;
    assign concluido   = concluido_q;
    assign erro        = erro_q;

endmodule

// File: doc/writeback_ctrl.md
# writeback_ctrl

Multicycle sequencer for the CPU register-file write-back path. Accepts one instruction at a time and steps it through execute, an optional data-memory wait, and a single write cycle. It drives the two select lines of the 3-input write-back mux: ALU result by default, data memory on `selecao1`, current PC on `selecao2`. It also drives the register-file write enable and the destination address.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5: width of destination register address.
- TIMEOUT_CICLOS, 16: maximum MEM_WAIT cycles before abort (used only with the watchdog macro); legal range 1..255.

Ports:
- clock  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- inicio  input  1  start request; sampled only in IDLE.
- tipo  input  2  write-back source: 00 ALU, 01 load (memory), 10 link (PC), 11 no-write.
- rd_entrada  input  REG_ADDR_WIDTH  destination register, latched with `inicio`.
- mem_pronto  input  1  data memory read data valid.
- mem_req  output  1  memory read request, held high in MEM_WAIT.
- selecao1  output  1  mux select: memory data.
- selecao2  output  1  mux select: PC.
- escreve_reg  output  1  register-file write enable, one cycle.
- rd_saida  output  REG_ADDR_WIDTH  latched destination address.
- ocupado  output  1  high whenever state is not IDLE.
- concluido  output  1  one-cycle pulse when an instruction retires.
- erro  output  1  one-cycle pulse on memory timeout.

## Operation
- States: IDLE, EXEC, MEM_WAIT, WRITE.
- IDLE:
  - `inicio=1` latches `tipo` and `rd_entrada`, then moves to EXEC.
  - `inicio=0` stays in IDLE.
- EXEC: one cycle.
  - tipo 01 goes to MEM_WAIT.
  - tipo 00 or 10 goes to WRITE.
  - tipo 11 returns to IDLE, pulses `concluido`, never asserts `escreve_reg`.
- MEM_WAIT:
  - `mem_req=1`.
  - `mem_pronto=1` moves to WRITE.
  - Otherwise stays in MEM_WAIT, or times out (see Configuration).
- WRITE:
  - `escreve_reg=1` and `concluido=1` for exactly this cycle.
  - Next state is IDLE.
- Select outputs are registered from the latched type and are stable from EXEC through WRITE.
  - Load: `selecao1=1`, `selecao2=0`.
  - Link: `selecao2=1`, `selecao1=0`.
  - ALU and no-write: both 0.
  - `selecao1` and `selecao2` are never high together.
- `rd_saida` holds the latched value until the next accepted `inicio`.
- `inicio` while `ocupado=1` is ignored; there is no queueing.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs go to 0, including `rd_saida`.
  - Any in-flight write is discarded, so `escreve_reg` never asserts for an instruction interrupted by reset.

## Timing
- ALU or link: `inicio` sampled at edge 0, EXEC in cycle 1, WRITE in cycle 2 (`escreve_reg` high), IDLE in cycle 3. Throughput is one instruction per 3 cycles.
- Load: WRITE occurs in the cycle after the edge that samples `mem_pronto=1`. With `mem_pronto` already high on MEM_WAIT entry, latency is 4 cycles.
- No-write: `concluido` pulses in cycle 2, directly from EXEC.
- `inicio` may be asserted in the same cycle `concluido` pulses; it is accepted on the following IDLE cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `WRITEBACK_CTRL_TIMEOUT_EN` defined:
  - An 8-bit watchdog clears on MEM_WAIT entry and increments each MEM_WAIT cycle.
  - At count TIMEOUT_CICLOS with `mem_pronto=0`, the block returns to IDLE, pulses `erro`, and does not write.
  - If `mem_pronto=1` in the same cycle the count reaches the limit, `mem_pronto` wins: normal WRITE, no `erro`.
- Macro undefined:
  - MEM_WAIT waits indefinitely.
  - `erro` is tied 0.
  - No watchdog logic is instantiated.

## Structure
- Package `writeback_ctrl_pkg`:
  - State encoding (2-bit).
  - tipo constants TIPO_ULA, TIPO_MEM, TIPO_PC, TIPO_NENHUM.
- Sub-module `writeback_watchdog`: counter with clear, enable and `expirou` output. Instantiated only under the macro.

## Test plan
- Reset, then ALU instruction `tipo=00`, `rd=5'd7`: `escreve_reg` high in cycle 2 only, `rd_saida=7`, both selects 0, `concluido` in cycle 2.
- Load `tipo=01`, `rd=3`, `mem_pronto` asserted 4 cycles after MEM_WAIT entry: `mem_req` high exactly 5 cycles, then WRITE with `selecao1=1`, `escreve_reg` for 1 cycle.
- Link `tipo=10` with `inicio` re-pulsed during EXEC: `selecao2=1` in WRITE, the second `inicio` is ignored, exactly one write.
- `tipo=11`: `concluido` pulses in cycle 2, `escreve_reg` stays 0 throughout.
- Load with `reset_n` dropped in MEM_WAIT: all outputs 0 immediately, no `escreve_reg`, next ALU instruction completes normally.
- Macro defined, TIMEOUT_CICLOS=4, `mem_pronto` never asserted: `erro` pulses after 4 MEM_WAIT cycles, no write. Repeat with `mem_pronto` arriving on the 4th cycle: normal write, `erro=0`.
